// File: rtl/equiv_pkg.sv
// equiv_pkg: state encoding and defaults shared by the equivalence checker files.
package equiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/equiv_checker_if.sv
// equiv_checker_if: stimulus/response and status bundle; master = harness side, slave = checker.
interface equiv_checker_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int CNT_W = 16
);
    logic             start;
    logic [N_IN-1:0]  stim;
    logic [N_OUT-1:0] y_ref;
    logic [N_OUT-1:0] y_dut;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic             first_fail_valid;
    logic [N_IN-1:0]  first_fail_vec;

    modport master (
        output start, y_ref, y_dut,
        input  stim, busy, done, pass, err_cnt, first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, y_ref, y_dut,
        output stim, busy, done, pass, err_cnt, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/equiv_checker.sv
// equiv_checker: exhaustive stimulus sweep comparing two implementations' outputs.
// Define EQUIV_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module equiv_checker
    import equiv_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 1,
    parameter int SETTLE = SETTLE_DEF,
    parameter int CNT_W  = 16
) (
    input logic            clk,
    input logic            rst,
    equiv_checker_if.slave bus
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffvec_q, ffvec_d;
    logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [CNT_W-1:0] err_cnt;

    logic go, chk, mism, fail, halt, settled;

    // Case-inequality so X/Z on either side is a mismatch in simulation
    assign mism    = N_OUT'(bus.y_ref) !== N_OUT'(bus.y_dut);
    assign go      = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign chk     = state_q == ST_CHECK;
    assign fail    = chk && mism;
    assign settled = state_q == ST_SETTLE && cnt_q == '0;
`ifdef EQUIV_STOP_ON_FAIL_EN
    assign halt = (&stim_q) || mism;
`else
    assign halt = &stim_q;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end

    always_comb
        state_d = go ? ST_SETTLE : settled ? ST_CHECK : chk ? (halt ? ST_DONE : ST_SETTLE) : state_q;

    always_comb begin
        stim_d  = go ? '0 : (chk && !halt) ? stim_q + 1'b1 : stim_q;
        cnt_d   = (go || (chk && !halt)) ? CW'(SETTLE - 1) :
                  (state_q == ST_SETTLE && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        ffv_d   = go ? 1'b0 : fail ? 1'b1 : ffv_q;
        ffvec_d = go ? '0 : (fail && !ffv_q) ? stim_q : ffvec_q;
    end

    // Status flags are registered, so they trail the state by one cycle
    always_comb begin
        busy_d = state_q == ST_SETTLE || state_q == ST_CHECK;
        done_d = state_q == ST_DONE && !bus.start;
        pass_d = done_d && err_cnt == '0;
    end

    sat_counter #(.W(CNT_W)) u_err (
        .clk   (clk),
        .rst   (rst),
        .clr_i (go),
        .inc_i (fail),
        .cnt_o (err_cnt)
    );

    assign bus.stim             = stim_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_cnt          = err_cnt;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
endmodule

// File: tb/tb_equiv_checker.sv
// tb_equiv_checker: NAND-vs-faulty-NAND sweeps checked against a per-vector mismatch model.
module tb_equiv_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    equiv_checker_if #(.N_IN(3), .N_OUT(1), .CNT_W(16)) b0 ();
    equiv_checker_if #(.N_IN(3), .N_OUT(1), .CNT_W(2))  b1 ();

    equiv_checker #(.N_IN(3), .N_OUT(1), .SETTLE(2), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    equiv_checker #(.N_IN(3), .N_OUT(1), .SETTLE(2), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    logic       start = 1'b0;
    logic [7:0] mask  = 8'h00;
    logic       xen   = 1'b0;
    logic [2:0] xv    = 3'd0;
    logic       xval;
    int checks = 0;
    int fails  = 0;

    function automatic logic ref_of(logic [2:0] v);
        return ~&v;
    endfunction

    function automatic logic dut_of(logic [2:0] v);
        return (xen && v == xv) ? xval : ref_of(v) ^ mask[v];
    endfunction

    assign b0.start = start;
    assign b1.start = start;
    assign b0.y_ref = ref_of(b0.stim);
    assign b0.y_dut = dut_of(b0.stim);
    assign b1.y_ref = ref_of(b1.stim);
    assign b1.y_dut = dut_of(b1.stim);

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sweep(string tag, logic [7:0] m, logic x_en, logic [2:0] x_v, int poke);
        int n, bc, cnt, first, lat, err, fstim;
        logic [2:0] vv;
        mask = m; xen = x_en; xv = x_v;
        cnt = 0; first = -1;
        for (int v = 0; v < 8; v++) begin
            vv = 3'(v);
            if (ref_of(vv) !== dut_of(vv)) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        lat = 8 * 3 + 1; err = cnt; fstim = 7;
`ifdef EQUIV_STOP_ON_FAIL_EN
        if (first >= 0) begin
            lat = (first + 1) * 3 + 1; err = 1; fstim = first;
        end
`endif
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, ".done_clr"}, 32'(b0.done), 0);
        check({tag, ".pass_clr"}, 32'(b0.pass), 0);
        n = 0; bc = 0;
        while (!b0.done && n < 200) begin
            if (b0.busy) bc++;
            start = (n == poke);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'(lat));
        check({tag, ".busy_cycles"}, 32'(bc), 32'(lat - 1));
        check({tag, ".busy_low"}, 32'(b0.busy), 0);
        check({tag, ".pass"}, 32'(b0.pass), 32'(err == 0));
        check({tag, ".err_cnt"}, 32'(b0.err_cnt), 32'(err));
        check({tag, ".err_sat"}, 32'(b1.err_cnt), 32'(err > 3 ? 3 : err));
        check({tag, ".done_sat"}, 32'(b1.done), 1);
        check({tag, ".ff_valid"}, 32'(b0.first_fail_valid), 32'(first >= 0));
        check({tag, ".ff_vec"}, 32'(b0.first_fail_vec), 32'(first >= 0 ? first : 0));
        check({tag, ".stim_hold"}, 32'(b0.stim), 32'(fstim));
        repeat (2) @(negedge clk);
        check({tag, ".done_hold"}, 32'(b0.done), 1);
    endtask

    task automatic check_cleared(string tag);
        check({tag, ".busy"}, 32'(b0.busy), 0);
        check({tag, ".done"}, 32'(b0.done), 0);
        check({tag, ".pass"}, 32'(b0.pass), 0);
        check({tag, ".err_cnt"}, 32'(b0.err_cnt), 0);
        check({tag, ".ff_valid"}, 32'(b0.first_fail_valid), 0);
        check({tag, ".ff_vec"}, 32'(b0.first_fail_vec), 0);
        check({tag, ".stim"}, 32'(b0.stim), 0);
    endtask

    initial begin
        xval = 1'bx;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sweep("total_fault", 8'hff, 1'b0, 3'd0, -1);
        sweep("equivalent_busy_poke", 8'h00, 1'b0, 3'd0, 5);
        sweep("single_fault_101", 8'h20, 1'b0, 3'd0, -1);
        sweep("x_at_010", 8'h00, 1'b1, 3'd2, -1);
        for (int i = 0; i < 6; i++)
            sweep($sformatf("rand%0d", i), 8'($urandom), 1'b0, 3'd0, -1);
        mask = 8'hff; xen = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_cleared("mid_reset");
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("idle_after_reset");
        sweep("after_reset", 8'h81, 1'b0, 3'd0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/equiv_checker.md
Name: equiv_checker

Overview:
Hardware response-side companion to our equivalence testbenches.
- Sweeps every input combination into two implementations of the same function, for example a CMOS-level and a gate-level model.
- Waits a settle time, samples and compares both outputs, and accumulates the result.
- Reports pass/fail, mismatch count and the first failing vector.
- Replaces one-shot `$monitor` eyeballing with an exhaustive, self-checking sweep.

Parameters:
- N_IN, 3, width of stimulus vector driven to both DUTs.
- N_OUT, 1, width of each DUT output.
- SETTLE, 2, cycles held per vector before sampling; legal range >= 1.
- CNT_W, 16, width of mismatch counter; counter saturates.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when not busy.
- stim  out  N_IN  stimulus vector driven to both DUTs.
- y_ref  in  N_OUT  output of reference implementation.
- y_dut  in  N_OUT  output of implementation under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep end until next start or reset.
- pass  out  1  valid when done; 1 iff zero mismatches.
- err_cnt  out  CNT_W  number of mismatching vectors, saturating.
- first_fail_valid  out  1  high once any mismatch is captured.
- first_fail_vec  out  N_IN  stim value of first mismatch.

Behaviour:
- Reset: async; all outputs 0 and state IDLE. A reset asserted mid-sweep aborts immediately, with no partial result retained.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE, on start:
  - stim <= 0; err_cnt, first_fail_* and done cleared.
  - Settle counter <= SETTLE-1; go to SETTLE.
- SETTLE: busy=1; stim held stable; counter decrements; at 0 go to CHECK.
- CHECK (1 cycle), mismatch test:
  - Mismatch = (y_ref != y_dut).
  - Under simulation, any X/Z bit on either input also counts as a mismatch (case-inequality).
- CHECK, on mismatch:
  - err_cnt increments unless already all-ones.
  - If !first_fail_valid, capture first_fail_vec <= stim and set first_fail_valid.
- CHECK, next state:
  - If stim == all-ones, go to DONE.
  - Else stim <= stim+1, reload counter, go to SETTLE.
- DONE: busy=0, done=1, pass=(err_cnt==0); stim holds its last value. start re-runs a full sweep, clearing stats as in IDLE.
- start while busy: ignored, no restart.
- start is sampled in IDLE/DONE only; start coincident with reset deassertion is ignored.
- Latency: done rises 2^N_IN*(SETTLE+1)+1 rising edges after the edge sampling start. With defaults this is 25 cycles.
- pass is 0 whenever done=0.
- Wrap-around: stim never wraps inside a sweep; the all-ones vector is the terminal condition.

Optional Feature:
- Macro: EQUIV_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE.
  - err_cnt = 1, pass = 0, stim frozen at the failing vector.
  - Latency is (k+1)*(SETTLE+1)+1, where k is the failing vector index.
- Undefined: the full sweep always completes and every mismatch is counted.

Decomposition:
- Shared package equiv_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_CHECK=2'd2, ST_DONE=2'd3.
  - Default SETTLE value.
- Sub-module sat_counter: parameterised width, with inc and clr inputs, saturating at all-ones. Used for err_cnt.
- The settle counter stays inline.

Test Plan:
1. Equivalent DUTs: both are 3-input NAND, start at cycle 2. Expected: busy for 24 cycles, done=1 at start+25, pass=1, err_cnt=0, first_fail_valid=0.
2. Single fault: y_dut inverted only for stim=3'b101. Expected: err_cnt=1, first_fail_vec=3'b101, pass=0.
3. Total fault: y_dut = ~y_ref always. Expected: err_cnt=8, first_fail_vec=3'b000. With CNT_W=2, err_cnt saturates at 3.
4. Control: reset asserted 10 cycles into a sweep → all outputs 0 immediately, IDLE. A start pulse while busy → no restart, done still at original cycle. Start in DONE → stats cleared and full new sweep.
5. With EQUIV_STOP_ON_FAIL_EN, fault at 3'b101 → done at start+19, stim=3'b101, err_cnt=1, pass=0.
6. X injection: y_dut=1'bx at stim=3'b010 → counted as mismatch, first_fail_vec=3'b010.
